// File: rtl/uart_pkg.sv
// Shared FSM state type, parity mode constants and baud divider helper
// for the buffered UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_STOP
  } uart_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  function automatic int div_calc(input int f_clk, input int baudrate);
    return f_clk / baudrate;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous show-ahead FIFO: rdata always presents the head entry, and
// a pointer pair with one wrap bit distinguishes full from empty.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW-1:0] CAPACITY = PW'(DEPTH);

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign level   = wr_ptr_q - rd_ptr_q;
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (level == CAPACITY);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  // NOTE: flops update with <= only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO-fed, LSB-first frames with optional
// parity and 1/2 stop bits, sent back-to-back while words are queued.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int BAUDRATE   = 9600,
  parameter int F_CLK      = 50_000_000,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [DATA_BITS-1:0]        data,
  input  logic                        valid,
  output logic                        ready,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                        idle,
  output logic                        q
);

  localparam int DIV = div_calc(F_CLK, BAUDRATE);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW  = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  if (DIV < 2) begin : g_chk_div
    $error("uart_tx_fifo: F_CLK / BAUDRATE must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_data
    $error("uart_tx_fifo: DATA_BITS must be 5..9");
  end
  if (PARITY != PAR_NONE && PARITY != PAR_EVEN && PARITY != PAR_ODD) begin : g_chk_par
    $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_chk_stop
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
  end

  uart_state_e          state_q, state_d;
  logic [CW-1:0]        baud_q, baud_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 q_q, q_d;

  logic                 push;
  logic                 pop;
  logic                 bit_end;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] fifo_rdata;

  // ready must stay low in reset so nothing is accepted into a FIFO being cleared.
  assign ready   = rst_n && !fifo_full;
  assign push    = valid && ready;
  assign idle    = (state_q == ST_IDLE) && fifo_empty;
  assign q       = q_q;
  assign bit_end = (baud_q == BAUD_LAST);

  uart_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (data),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  always_comb begin
    state_d = state_q;
    baud_d  = bit_end ? '0 : baud_q + CW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    q_d     = 1'b1;
    pop     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        pop    = !fifo_empty;
      end
      ST_START: begin
        q_d = 1'b0;
        if (bit_end) begin
          state_d = ST_DATA;
          bit_d   = '0;
        end
      end
      ST_DATA: begin
        q_d = shift_q[0];
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
            state_d = (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      ST_PAR: begin
        q_d = par_q;
        if (bit_end) begin
          state_d = ST_STOP;
          bit_d   = '0;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (bit_q != STOP_LAST) begin
            bit_d = bit_q + BW'(1);
          end else if (fifo_empty) begin
            state_d = ST_IDLE;
          end else begin
            pop = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Loading from the head is shared by IDLE and the last stop-bit cycle,
    // which is what makes consecutive frames gapless.
    if (pop) begin
      shift_d = fifo_rdata;
      par_d   = (^fifo_rdata) ^ (PARITY == PAR_ODD);
      baud_d  = '0;
      bit_d   = '0;
      state_d = ST_START;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      q_q     <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      q_q     <= q_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: four instances (8N1, 8E1, 8O1, 7N2) at DIV=4,
// one selected at a time, with the serial line recorded every cycle.
module tb_uart_tx_fifo;

  logic       clk;
  logic       rst_n;
  logic [7:0] data;
  logic       valid;
  logic [1:0] sel;
  logic [3:0] valid_v;
  logic [3:0] ready_v;
  logic [3:0] idle_v;
  logic [3:0] q_v;
  logic [2:0] level_v [4];

  logic       ready_s, idle_s, q_s;
  logic [2:0] level_s;

  int   n_checks;
  int   n_fail;
  logic cap_en;
  logic cap [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign valid_v = valid ? (4'b0001 << sel) : 4'b0000;
  assign ready_s = ready_v[sel];
  assign idle_s  = idle_v[sel];
  assign q_s     = q_v[sel];
  assign level_s = level_v[sel];

  always @(negedge clk) if (cap_en) cap.push_back(q_s);

  uart_tx_fifo #(.BAUDRATE(10), .F_CLK(40), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4))
    u_8n1 (.clk(clk), .rst_n(rst_n), .data(data), .valid(valid_v[0]), .ready(ready_v[0]),
           .level(level_v[0]), .idle(idle_v[0]), .q(q_v[0]));
  uart_tx_fifo #(.BAUDRATE(10), .F_CLK(40), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4))
    u_8e1 (.clk(clk), .rst_n(rst_n), .data(data), .valid(valid_v[1]), .ready(ready_v[1]),
           .level(level_v[1]), .idle(idle_v[1]), .q(q_v[1]));
  uart_tx_fifo #(.BAUDRATE(10), .F_CLK(40), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4))
    u_8o1 (.clk(clk), .rst_n(rst_n), .data(data), .valid(valid_v[2]), .ready(ready_v[2]),
           .level(level_v[2]), .idle(idle_v[2]), .q(q_v[2]));
  uart_tx_fifo #(.BAUDRATE(10), .F_CLK(40), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4))
    u_7n2 (.clk(clk), .rst_n(rst_n), .data(data[6:0]), .valid(valid_v[3]), .ready(ready_v[3]),
           .level(level_v[3]), .idle(idle_v[3]), .q(q_v[3]));

  // Expected line level i cycles into a frame (4 cycles per bit); par < 0 means no parity bit.
  function automatic logic exp_bit(input logic [7:0] w, input int nbits, input int par, input int i);
    int b;
    b = i / 4;
    if (b == 0) return 1'b0;
    if (b <= nbits) return w[b-1];
    if (par >= 0 && b == nbits + 1) return par[0];
    return 1'b1;
  endfunction

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  // Call just after a rising edge; returns 1 time unit after the accepting edge.
  task automatic push_one(input logic [7:0] w);
    int   n;
    logic r;
    data  = w;
    valid = 1'b1;
    n     = 0;
    r     = 1'b0;
    while (!r && n < 100) begin
      @(negedge clk);
      r = ready_s;
      @(posedge clk);
      n++;
    end
    #1 valid = 1'b0;
    n_checks++;
    if (r !== 1'b1) begin
      $display("FAIL push_timeout: word %0h not accepted within %0d cycles", w, n);
      n_fail++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (ready_v !== 4'b0000) begin
      $display("FAIL reset_ready_low: got %b expected 0000", ready_v);
      n_fail++;
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (q_v !== 4'b1111) begin
      $display("FAIL reset_q: got %b expected 1111", q_v);
      n_fail++;
    end
    n_checks++;
    if (idle_v !== 4'b1111) begin
      $display("FAIL reset_idle: got %b expected 1111", idle_v);
      n_fail++;
    end
    n_checks++;
    if (ready_v !== 4'b1111) begin
      $display("FAIL reset_ready: got %b expected 1111", ready_v);
      n_fail++;
    end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (level_v[k] !== 3'd0) begin
        $display("FAIL reset_level[%0d]: got %0d expected 0", k, level_v[k]);
        n_fail++;
      end
    end
  endtask

  task automatic test_single_frames();
    int         v_sel   [4] = '{0, 1, 2, 3};
    logic [7:0] v_word  [4] = '{8'h55, 8'h07, 8'h07, 8'h41};
    int         v_nbits [4] = '{8, 8, 8, 7};
    int         v_par   [4] = '{-1, 1, 0, -1};
    int         v_len   [4] = '{40, 44, 44, 40};
    logic       e;
    for (int t = 0; t < 4; t++) begin
      sel = 2'(v_sel[t]);
      cap.delete();
      align();
      push_one(v_word[t]);
      cap_en = 1'b1;
      @(negedge clk);
      n_checks++;
      if (level_s !== 3'd1 || idle_s !== 1'b0) begin
        $display("FAIL frame%0d_after_accept: level %0d idle %b expected level 1 idle 0", t, level_s, idle_s);
        n_fail++;
      end
      repeat (v_len[t] + 11) @(negedge clk);
      #1 cap_en = 1'b0;
      for (int j = 0; j < v_len[t] + 12; j++) begin
        if (j < 2 || j >= v_len[t] + 2) e = 1'b1;
        else e = exp_bit(v_word[t], v_nbits[t], v_par[t], j - 2);
        n_checks++;
        if (cap[j] !== e) begin
          $display("FAIL frame%0d_q[%0d]: got %b expected %b", t, j, cap[j], e);
          n_fail++;
        end
      end
      n_checks++;
      if (idle_s !== 1'b1 || level_s !== 3'd0) begin
        $display("FAIL frame%0d_end_idle: idle %b level %0d expected idle 1 level 0", t, idle_s, level_s);
        n_fail++;
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic e;
    sel = 2'd0;
    align();
    push_one(8'h00);
    push_one(8'h3C);
    push_one(8'hC3);
    @(negedge clk);
    n_checks++;
    if (level_s !== 3'd2) begin
      $display("FAIL midrst_queued: level %0d expected 2", level_s);
      n_fail++;
    end
    repeat (16) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (q_s !== 1'b0 || level_s !== 3'd2 || ready_s !== 1'b0) begin
      $display("FAIL midrst_before: q %b level %0d ready %b expected q 0 level 2 ready 0", q_s, level_s, ready_s);
      n_fail++;
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (q_s !== 1'b1 || level_s !== 3'd0 || idle_s !== 1'b1 || ready_s !== 1'b1) begin
      $display("FAIL midrst_after: q %b level %0d idle %b ready %b expected 1 0 1 1", q_s, level_s, idle_s, ready_s);
      n_fail++;
    end
    cap.delete();
    align();
    push_one(8'hA3);
    cap_en = 1'b1;
    repeat (60) @(negedge clk);
    #1 cap_en = 1'b0;
    for (int j = 0; j < 60; j++) begin
      if (j < 2 || j >= 42) e = 1'b1;
      else e = exp_bit(8'hA3, 8, -1, j - 2);
      n_checks++;
      if (cap[j] !== e) begin
        $display("FAIL midrst_frame_q[%0d]: got %b expected %b", j, cap[j], e);
        n_fail++;
      end
    end
    n_checks++;
    if (idle_s !== 1'b1) begin
      $display("FAIL midrst_end_idle: got %b expected 1", idle_s);
      n_fail++;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] words [6];
    int         acc [6];
    int         idx, cyc, guard, f;
    logic       r, drop_checked, e;
    words = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h5A, 8'h00};
    acc   = '{0, 0, 0, 0, 0, 0};
    sel   = 2'd0;
    cap.delete();
    idx = 0;
    cyc = 0;
    drop_checked = 1'b0;
    align();
    data  = words[0];
    valid = 1'b1;
    while (idx < 6 && cyc < 300) begin
      @(negedge clk);
      r = ready_s;
      if (idx == 5 && !drop_checked) begin
        drop_checked = 1'b1;
        n_checks++;
        if (r !== 1'b0 || level_s !== 3'd4) begin
          $display("FAIL b2b_full: ready %b level %0d expected ready 0 level 4", r, level_s);
          n_fail++;
        end
      end
      @(posedge clk);
      if (r) begin
        if (idx == 5) words[5] = data;
        acc[idx] = cyc;
        idx++;
      end
      cyc++;
      #1;
      if (idx == 1 && r) cap_en = 1'b1;
      if (idx < 5) data = words[idx];
      else if (idx == 5) data = 8'hC0 ^ 8'(cyc);
      else valid = 1'b0;
    end
    valid = 1'b0;
    n_checks++;
    if (idx != 6) begin
      $display("FAIL b2b_accepts: got %0d words expected 6", idx);
      n_fail++;
    end
    n_checks++;
    if (acc[4] - acc[0] != 4) begin
      $display("FAIL b2b_fifth_accept: offset %0d expected 4", acc[4] - acc[0]);
      n_fail++;
    end
    n_checks++;
    if (acc[5] - acc[0] != 42) begin
      $display("FAIL b2b_sixth_accept: offset %0d expected 42", acc[5] - acc[0]);
      n_fail++;
    end
    guard = 0;
    while (cap.size() < 250 && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    #1 cap_en = 1'b0;
    for (int j = 0; j < 250; j++) begin
      if (j < 2 || j >= 242) begin
        e = 1'b1;
      end else begin
        f = (j - 2) / 40;
        e = exp_bit(words[f], 8, -1, (j - 2) % 40);
      end
      n_checks++;
      if (cap[j] !== e) begin
        $display("FAIL b2b_q[%0d]: got %b expected %b", j, cap[j], e);
        n_fail++;
      end
    end
    n_checks++;
    if (idle_s !== 1'b1 || level_s !== 3'd0) begin
      $display("FAIL b2b_end_idle: idle %b level %0d expected idle 1 level 0", idle_s, level_s);
      n_fail++;
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    data     = 8'h00;
    valid    = 1'b0;
    sel      = 2'd0;
    cap_en   = 1'b0;
    test_reset();
    test_single_frames();
    test_reset_midframe();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter for the serial debug/telemetry path. It accepts words over a valid/ready handshake into an internal FIFO. It serialises them LSB-first with configurable data width, optional even/odd parity and one or two stop bits. Consecutive frames go out back-to-back with no idle gap.

## Interface
- `BAUDRATE`, 9600, line rate in bit/s
- `F_CLK`, 50_000_000, clock frequency in Hz; `DIV = F_CLK / BAUDRATE` clocks per bit (integer division); `DIV >= 2` required, else elaboration error
- `DATA_BITS`, 8, data bits per frame, 5..9
- `PARITY`, 0, 0 = none, 1 = even, 2 = odd; other values are an elaboration error
- `STOP_BITS`, 1, 1 or 2
- `FIFO_DEPTH`, 4, input FIFO entries, power of two, >= 2
- `clk`  in  1  single clock, all logic on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `data`  in  DATA_BITS  word to send, sampled when `valid && ready`
- `valid`  in  1  producer has a word on `data`
- `ready`  out  1  FIFO can accept; equals `!full`; forced 0 while `rst_n` is low
- `level`  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy (excludes the word in the shifter)
- `idle`  out  1  FSM in IDLE and FIFO empty
- `q`  out  1  serial line, registered, idles high

## Operation
- Reset values: `q`=1, `idle`=1, `level`=0, FIFO pointers cleared, FSM=IDLE, baud counter=0. Reset mid-frame aborts the frame. Buffered words are discarded.
- FSM states: IDLE, START, DATA, PAR, STOP.
- IDLE: if FIFO non-empty, pop the head into the shift register, clear the baud counter, go to START.
- START: `q`=0.
- DATA: `q`=shift[0], shift right each bit, DATA_BITS bits.
- PAR (present only if PARITY!=0): `q`= XOR of the data bits (even), or its inverse (odd).
- STOP: `q`=1 for STOP_BITS bits.
- Every bit lasts exactly DIV cycles. The baud counter runs 0..DIV-1 and wraps. A bit boundary is the cycle where the counter equals DIV-1.
- Frame length is exactly (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * DIV cycles.
- At the last cycle of the final stop bit:
  - FIFO non-empty: pop and go directly to START, so the next start bit begins on the following edge.
  - FIFO empty: go to IDLE.
- Parity is computed from the word at pop time and held in a register. It is not recomputed from the shifting register.
- FIFO push and pop in the same cycle: `level` unchanged. Push when full cannot occur because `ready` is 0.
- `data` changes while `ready` is 0 are ignored. Each accepted word is transmitted exactly once, in order.

## Timing
- Word accepted at edge k into an empty FIFO with the FSM in IDLE: `level`=1 after k; pop at edge k+1; `q` falls at edge k+2 (2-cycle latency).
- `ready` is combinational from the FIFO full flag, with no path from `valid`.
- `idle` is combinational from FSM state and FIFO empty. It deasserts the cycle after the first accept and reasserts the cycle after the last stop bit ends.
- Maximum words in flight: FIFO_DEPTH + 1 (FIFO plus shifter).
- Baud counter width: $clog2(DIV). Bit counter width: $clog2(DATA_BITS+1). No arithmetic wider than these.

## Structure
- Package `uart_pkg`:
  - FSM state enum.
  - Parity mode constants `PAR_NONE`/`PAR_EVEN`/`PAR_ODD`.
  - Function `div_calc(F_CLK, BAUDRATE)` returning DIV.
- Sub-module `uart_fifo`: synchronous FIFO with active-low synchronous reset, parameterised WIDTH/DEPTH, push/pop/full/empty/level ports. The top holds the FSM, baud counter, shifter and parity register.

## Test plan
All cases use F_CLK=40, BAUDRATE=10 (DIV=4).
- 8N1, push 0x55 once -> `q` low 4 cycles, then 1,0,1,0,1,0,1,0 for 4 cycles each, then high 4 cycles; frame 40 cycles; `q` falls 2 cycles after accept; `idle` returns to 1.
- 8E1 push 0x07 -> parity bit 1; 8O1 push 0x07 -> parity bit 0; frame 44 cycles in both cases.
- DATA_BITS=7, STOP_BITS=2, push 7'h41 -> bits 1,0,0,0,0,0,1, then `q` high 8 cycles; frame 40 cycles.
- FIFO_DEPTH=4, `valid` held high with 6 distinct words -> `ready` drops after the 5th accept and rises when a pop frees an entry; all 6 frames sent in order, back-to-back, with no idle cycle between stop and start.
- Assert `rst_n`=0 for 1 cycle during data bit 3, with 2 words queued -> `q`=1, `level`=0, `idle`=1 after that edge; a following push of 0xA3 transmits a clean frame and nothing else.
- `valid`=1 with `ready`=0 while `data` toggles -> nothing accepted; once `ready` rises, the value present on that cycle is the one sent.
